// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit that owns the HI/LO registers.
//
// Runs mult/multu/div/divu as multi-cycle operations and holds busy high
// for the whole operation. Handles mthi/mtlo as single-edge writes while idle.
// The result is committed to HI/LO only at the final busy edge.
//
// State table:
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | no op in flight; accepts start, and mthi/mtlo write HI/LO
//   MULT_BUSY | mult/multu in flight; counter runs down to the commit edge
//   DIV_BUSY  | div/divu in flight; counter runs down to the commit edge
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-low reset
//   start  - op-valid strobe from E stage
//   md_op  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   A, B   - forwarded rs / rt operands
//   busy   - multi-cycle op in progress
//   hi_E   - HI register
//   lo_E   - LO register
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi_E,
    output logic [31:0] lo_E
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) < 4) ? 4 : $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MULT_BUSY,
        DIV_BUSY
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic             sgn_q, sgn_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    // Arithmetic on the latched operands. Multiplying the 64-bit sign- or
    // zero-extended operands and keeping the low 64 bits gives the correct
    // signed or unsigned product without needing signed types.
    logic [63:0] ext_a, ext_b, prod;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, div_b;
    logic [31:0] uq, ur, quo, rem;

    always_comb begin
        ext_a = {{32{sgn_q & op_a_q[31]}}, op_a_q};
        ext_b = {{32{sgn_q & op_b_q[31]}}, op_b_q};
        prod  = ext_a * ext_b;

        // Signed divide through magnitudes: quotient truncates toward zero,
        // remainder follows the dividend. 0x80000000 / -1 falls out naturally
        // as magnitude 0x80000000 with no sign flip.
        neg_a = sgn_q & op_a_q[31];
        neg_b = sgn_q & op_b_q[31];
        mag_a = neg_a ? (~op_a_q + 32'd1) : op_a_q;
        mag_b = neg_b ? (~op_b_q + 32'd1) : op_b_q;
        // Avoid a divide by zero in hardware; that result is never committed.
        div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
        uq    = mag_a / div_b;
        ur    = mag_a % div_b;
        quo   = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
        rem   = neg_a ? (~ur + 32'd1) : ur;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (md_op)
                        3'd1, 3'd2: begin
                            op_a_d  = A;
                            op_b_d  = B;
                            sgn_d   = (md_op == 3'd1);
                            cnt_d   = MULT_LOAD;
                            state_d = MULT_BUSY;
                        end
                        3'd3, 3'd4: begin
                            op_a_d  = A;
                            op_b_d  = B;
                            sgn_d   = (md_op == 3'd3);
                            cnt_d   = DIV_LOAD;
                            state_d = DIV_BUSY;
                        end
                        3'd5:    hi_d = A;
                        3'd6:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            MULT_BUSY: begin
                if (cnt_q == '0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DIV_BUSY: begin
                if (cnt_q == '0) begin
                    // Divide by zero still spends the full time but leaves HI/LO alone.
                    if (op_b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign hi_E = hi_q;
    assign lo_E = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi_E;
    logic [31:0] lo_E;

    int n_total;
    int n_pass;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .md_op(md_op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .hi_E (hi_E),
        .lo_E (lo_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one multi-cycle op, count busy cycles (bounded), then check HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n_exp,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        n = 0;
        while (busy && n < 64) begin
            if (n == 1) begin
                check({tag, " hi during busy"}, hi_E, m_hi);
                check({tag, " lo during busy"}, lo_E, m_lo);
            end
            n++;
            tick();
        end
        check({tag, " busy cycles"}, 32'(n), 32'(n_exp));
        check({tag, " hi"}, hi_E, exp_hi);
        check({tag, " lo"}, lo_E, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        int n;
        n_total = 0;
        n_pass  = 0;
        reset = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;

        // 1. reset
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", hi_E, 32'd0);
        check("reset lo", lo_E, 32'd0);

        // 2. mult -1 * 2
        run_op("mult", 3'd1, 32'hFFFFFFFF, 32'h2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);

        // 3. multu, divu
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'h2, 5, 32'h00000001, 32'hFFFFFFFE);
        run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);

        // 4. signed divide and edge cases
        run_op("div neg", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
        run_op("div zero", 3'd3, 32'd5, 32'd0, 10, m_hi, m_lo);
        run_op("divu zero", 3'd4, 32'd9, 32'd0, 10, m_hi, m_lo);

        // 5. mthi / mtlo
        start = 1'b1;
        md_op = 3'd5;
        A     = 32'h12345678;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        check("mthi hi", hi_E, 32'h12345678);
        check("mthi busy", {31'd0, busy}, 32'd0);
        check("mthi lo kept", lo_E, m_lo);
        m_hi = 32'h12345678;

        start = 1'b1;
        md_op = 3'd6;
        A     = 32'h9ABCDEF0;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        check("mtlo lo", lo_E, 32'h9ABCDEF0);
        check("mtlo busy", {31'd0, busy}, 32'd0);
        m_lo = 32'h9ABCDEF0;

        // reserved op is a no-op
        start = 1'b1;
        md_op = 3'd7;
        A     = 32'h0BADF00D;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        check("op7 busy", {31'd0, busy}, 32'd0);
        check("op7 hi", hi_E, m_hi);
        check("op7 lo", lo_E, m_lo);

        // mult 3*4 with starts while busy, including one at the commit edge
        start = 1'b1;
        md_op = 3'd1;
        A     = 32'd3;
        B     = 32'd4;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        n = 0;
        while (busy && n < 64) begin
            start = 1'b0;
            md_op = 3'd0;
            if (n == 2) begin
                start = 1'b1;
                md_op = 3'd6;
                A     = 32'h0000DEAD;
            end else if (n == 3) begin
                start = 1'b1;
                md_op = 3'd3;
                A     = 32'd100;
                B     = 32'd7;
            end else if (n == 4) begin
                start = 1'b1;
                md_op = 3'd5;
                A     = 32'h00000055;
            end
            n++;
            tick();
        end
        start = 1'b0;
        md_op = 3'd0;
        check("ignored busy cycles", 32'(n), 32'd5);
        check("ignored hi", hi_E, 32'd0);
        check("ignored lo", lo_E, 32'd12);
        tick();
        check("ignored no restart", {31'd0, busy}, 32'd0);
        check("ignored hi after", hi_E, 32'd0);

        // 6. reset mid-operation
        start = 1'b1;
        md_op = 3'd3;
        A     = 32'd100;
        B     = 32'd7;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        check("midrst busy before", {31'd0, busy}, 32'd1);
        tick();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst hi", hi_E, 32'd0);
        check("midrst lo", lo_E, 32'd0);
        reset = 1'b1;
        repeat (12) tick();
        check("midrst late busy", {31'd0, busy}, 32'd0);
        check("midrst late hi", hi_E, 32'd0);
        check("midrst late lo", lo_E, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the P6 pipeline.
- Executes mult/multu/div/divu over multiple cycles and owns the HI/LO registers.
- Handles mthi/mtlo writes.
- Its hi_E/lo_E outputs feed the E-stage result select (ALU result vs HI vs LO). Its busy output feeds the hazard unit, which stalls any following md instruction.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (must be ≥1)
- DIV_CYCLES, 10, busy duration for div/divu (must be ≥1)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising edge of clk
- start  input  1  op-valid strobe from E stage; one cycle per instruction
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A  input  32  forwarded rs value (E stage)
- B  input  32  forwarded rt value (E stage)
- busy  output  1  multi-cycle op in progress
- hi_E  output  32  current HI register
- lo_E  output  32  current LO register

Behaviour:
- Reset (reset=0 at an edge): state→IDLE, counter→0, busy→0, hi_E→0, lo_E→0. This applies mid-operation: the pending result is discarded and HI/LO are not written.
- States: IDLE, MULT_BUSY, DIV_BUSY. Internal registers:
  - 32-bit op_a, op_b latched at start
  - pending 64-bit result {res_hi, res_lo}
  - counter of width ≥4 bits
  - op kind (signed/unsigned)
- IDLE, start=1 at edge k:
  - md_op 1/2: latch A, B. Compute the product: mult is signed 32x32→64 (sign-extend both), multu is zero-extended. Go to MULT_BUSY with counter=MULT_CYCLES-1.
  - md_op 3/4: latch A, B. Go to DIV_BUSY with counter=DIV_CYCLES-1.
  - md_op 5: hi_E←A at edge k, stay IDLE, busy stays 0.
  - md_op 6: lo_E←A at edge k, stay IDLE, busy stays 0.
  - md_op 0/7: no effect.
- Busy window:
  - busy=1 after edge k through edge k+N, where N is the op's cycle parameter. busy is high for exactly N cycles.
  - At edge k+N: hi_E/lo_E take the result, busy→0, state→IDLE.
  - The result is visible from cycle k+N onward.
- Busy states: each edge decrements the counter. When the counter is 0 at an edge, commit and return to IDLE.
- Result computation may be a single combinational operation captured at start or iterative. Either way, outputs change only at the commit edge.
- Divide rules:
  - lo=quotient, hi=remainder.
  - div is signed: quotient truncates toward zero, remainder takes the sign of the dividend.
  - divu is unsigned.
  - Divisor 0 (div or divu): busy runs the full DIV_CYCLES, then HI/LO stay unchanged.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000. No trap.
- start=1 while busy=1 (any md_op, including mthi/mtlo): ignored; the in-flight op is unaffected. The hazard unit guarantees this does not happen in correct operation.
- Simultaneous events: a start at the commit edge is also ignored, because busy is still 1 at that edge. A new op may start at edge k+N+1 at the earliest.
- hi_E and lo_E are direct register outputs with no combinational path from inputs.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release → busy=0, hi_E=0, lo_E=0.
2. mult: start, md_op=1, A=0xFFFFFFFF, B=0x00000002 → busy high exactly 5 cycles; then hi_E=0xFFFFFFFF, lo_E=0xFFFFFFFE. HI/LO are unchanged during the busy cycles.
3. multu then divu:
   - multu with A=0xFFFFFFFF, B=2 → hi_E=0x00000001, lo_E=0xFFFFFFFE after 5 cycles.
   - Next, divu with A=7, B=2 → busy 10 cycles; then lo_E=3, hi_E=1.
4. Signed div and edge cases:
   - div with A=0xFFFFFFF9 (−7), B=2 → lo_E=0xFFFFFFFD, hi_E=0xFFFFFFFF.
   - div 0x80000000/0xFFFFFFFF → lo_E=0x80000000, hi_E=0.
   - div by 0 (A=5, B=0) → after 10 busy cycles HI/LO are unchanged.
5. mthi/mtlo and ignored start:
   - mthi A=0x12345678 → hi_E=0x12345678 on the next cycle, busy stays 0.
   - mtlo A=0x9ABCDEF0 → lo_E=0x9ABCDEF0.
   - Start mult(3,4); during busy pulse start with mtlo A=0xDEAD and with div → both ignored; final hi_E=0, lo_E=12, busy high 5 cycles total.
6. Reset mid-operation: start div(100,7); drive reset=0 at busy cycle 4 → next cycle busy=0, hi_E=0, lo_E=0. After release, no late commit occurs.
